lcd_img_proc: RTL and testbench

Parametrised image-window controller. After reset it loads an IMG_W x IMG_H image from a synchronous ROM into an internal pixel buffer. It then executes host commands on a movable 2x2 window: shift, max, min, average, rotate and mirror. On request it writes the whole image back to RAM. This generalises the fixed 8x8 controller to arbitrary image geometry and pixel width, adds a 1-cycle-latency ROM model, and supports repeated write-backs.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_pool_2x2.sv | 36 +++
 rtl/lcd_img_proc.sv | 177 +++++++++++++++++
 tb/tb_lcd_img_proc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
//============================================================================
// lcd_pkg : opcodes, FSM encoding and pixel-index helper for lcd_img_proc
// Revision: 1.0
//============================================================================
`default_nettype none

package lcd_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_MAX      = 4'd5;
  localparam logic [3:0] CMD_MIN      = 4'd6;
  localparam logic [3:0] CMD_AVG      = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
  localparam logic [3:0] CMD_ROT_CW   = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Row-major linear index of pixel (x,y) in an image img_w pixels wide
  function automatic int pix_idx(input int x, input int y, input int img_w);
    return y * img_w + x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_pool_2x2.sv
//============================================================================
// lcd_pool_2x2 : combinational max / min / floor-average of four pixels
// Revision: 1.0
//============================================================================
`default_nettype none

module lcd_pool_2x2 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] pix_max,
  output logic [DATA_W-1:0] pix_min,
  output logic [DATA_W-1:0] pix_avg
);

  logic [DATA_W-1:0] w_max01, w_max23, w_min01, w_min23;
  logic [DATA_W+1:0] w_sum;

  always_comb begin
    w_max01 = (p0 > p1) ? p0 : p1;
    w_max23 = (p2 > p3) ? p2 : p3;
    w_min01 = (p0 < p1) ? p0 : p1;
    w_min23 = (p2 < p3) ? p2 : p3;
    pix_max = (w_max01 > w_max23) ? w_max01 : w_max23;
    pix_min = (w_min01 < w_min23) ? w_min01 : w_min23;
    // Two guard bits keep the four-pixel sum exact
    w_sum   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    pix_avg = w_sum[DATA_W+1:2];
  end

endmodule

`default_nettype wire

// File: rtl/lcd_img_proc.sv
//============================================================================
// lcd_img_proc : ROM-loaded pixel buffer with 2x2 window commands and RAM write-back
// Revision: 1.0
//============================================================================
`default_nettype none

module lcd_img_proc
  import lcd_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] rom_q,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_a,
  output logic              ram_valid,
  output logic [DATA_W-1:0] ram_d,
  output logic [ADDR_W-1:0] ram_a,
  output logic              busy,
  output logic              done
);

  localparam int c_N  = IMG_W * IMG_H;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_XW = $clog2(IMG_W);
  localparam int c_YW = $clog2(IMG_H);
  localparam int c_CW = ADDR_W + 1;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_pix [c_N];
  logic [c_XW-1:0]   r_x;
  logic [c_YW-1:0]   r_y;
  logic [3:0]        r_cmd;
  logic [c_CW-1:0]   r_cnt;

  logic [c_IW-1:0]   w_tl, w_tr, w_bl, w_br;
  logic [DATA_W-1:0] w_max, w_min, w_avg;
  logic              w_ld_last, w_wr_last;

  assign w_tl = c_IW'(pix_idx(int'(r_x),     int'(r_y),     IMG_W));
  assign w_tr = c_IW'(pix_idx(int'(r_x) + 1, int'(r_y),     IMG_W));
  assign w_bl = c_IW'(pix_idx(int'(r_x),     int'(r_y) + 1, IMG_W));
  assign w_br = c_IW'(pix_idx(int'(r_x) + 1, int'(r_y) + 1, IMG_W));

  assign w_ld_last = (r_cnt == c_CW'(c_N));
  assign w_wr_last = (ram_a == ADDR_W'(c_N - 1));

  lcd_pool_2x2 #(.DATA_W(DATA_W)) u_pool (
    .p0      (r_pix[w_tl]),
    .p1      (r_pix[w_tr]),
    .p2      (r_pix[w_bl]),
    .p3      (r_pix[w_br]),
    .pix_max (w_max),
    .pix_min (w_min),
    .pix_avg (w_avg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_ld_last) w_next = ST_IDLE;
      ST_IDLE:  if (cmd_valid) w_next = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
      ST_EXEC:  w_next = ST_IDLE;
      ST_WRITE: if (w_wr_last) w_next = ST_IDLE;
      default:  w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_rd    <= 1'b1;
      rom_a     <= '0;
      ram_valid <= 1'b0;
      ram_a     <= '0;
      ram_d     <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      r_x       <= c_XW'(IMG_W / 2 - 1);
      r_y       <= c_YW'(IMG_H / 2 - 1);
      r_cmd     <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < c_N; i++) r_pix[i] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          // ROM data lags its address by one cycle, so capture trails the count
          if (r_cnt != '0) r_pix[c_IW'(r_cnt - 1'b1)] <= rom_q;
          if (w_ld_last) begin
            busy  <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt < c_CW'(c_N - 1)) rom_a <= rom_a + 1'b1;
            else                         rom_rd <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd <= cmd;
            busy  <= 1'b1;
            if (cmd == CMD_WRITE) begin
              ram_valid <= 1'b1;
              ram_a     <= '0;
              ram_d     <= r_pix[0];
            end
          end
        end
        ST_EXEC: begin
          busy <= 1'b0;
          case (r_cmd)
            CMD_UP:    if (r_y != '0) r_y <= r_y - 1'b1;
            CMD_DOWN:  if (r_y < c_YW'(IMG_H - 2)) r_y <= r_y + 1'b1;
            CMD_LEFT:  if (r_x != '0) r_x <= r_x - 1'b1;
            CMD_RIGHT: if (r_x < c_XW'(IMG_W - 2)) r_x <= r_x + 1'b1;
            CMD_MAX: begin
              r_pix[w_tl] <= w_max; r_pix[w_tr] <= w_max;
              r_pix[w_bl] <= w_max; r_pix[w_br] <= w_max;
            end
            CMD_MIN: begin
              r_pix[w_tl] <= w_min; r_pix[w_tr] <= w_min;
              r_pix[w_bl] <= w_min; r_pix[w_br] <= w_min;
            end
            CMD_AVG: begin
              r_pix[w_tl] <= w_avg; r_pix[w_tr] <= w_avg;
              r_pix[w_bl] <= w_avg; r_pix[w_br] <= w_avg;
            end
            CMD_ROT_CCW: begin
              r_pix[w_tl] <= r_pix[w_tr]; r_pix[w_tr] <= r_pix[w_br];
              r_pix[w_br] <= r_pix[w_bl]; r_pix[w_bl] <= r_pix[w_tl];
            end
            CMD_ROT_CW: begin
              r_pix[w_tl] <= r_pix[w_bl]; r_pix[w_bl] <= r_pix[w_br];
              r_pix[w_br] <= r_pix[w_tr]; r_pix[w_tr] <= r_pix[w_tl];
            end
            CMD_MIRROR_X: begin
              r_pix[w_tl] <= r_pix[w_bl]; r_pix[w_bl] <= r_pix[w_tl];
              r_pix[w_tr] <= r_pix[w_br]; r_pix[w_br] <= r_pix[w_tr];
            end
            CMD_MIRROR_Y: begin
              r_pix[w_tl] <= r_pix[w_tr]; r_pix[w_tr] <= r_pix[w_tl];
              r_pix[w_bl] <= r_pix[w_br]; r_pix[w_br] <= r_pix[w_bl];
            end
            default: ;
          endcase
        end
        ST_WRITE: begin
          if (w_wr_last) begin
            ram_valid <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            ram_a <= ram_a + 1'b1;
            ram_d <= r_pix[c_IW'(ram_a + 1'b1)];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_img_proc.sv
//============================================================================
// tb_lcd_img_proc : directed self-checking bench, 8x8x8 ramp and 16x4x10 instances
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_lcd_img_proc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = '0, cmd2 = '0;
  logic       cmd_valid = 1'b0, cmd_valid2 = 1'b0;

  logic [7:0] rom_q, ram_d;
  logic [5:0] rom_a, ram_a;
  logic       rom_rd, ram_valid, busy, done;

  logic [9:0] rom_q2, ram_d2;
  logic [5:0] rom_a2, ram_a2;
  logic       rom_rd2, ram_valid2, busy2, done2;

  logic [7:0] rom1 [64];
  logic [9:0] rom2 [64];
  int         model1 [64];
  int         model2 [64];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd)  rom_q  <= rom1[rom_a];
  always @(posedge clk) if (rom_rd2) rom_q2 <= rom2[rom_a2];

  lcd_img_proc dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .rom_q(rom_q),
    .rom_rd(rom_rd), .rom_a(rom_a), .ram_valid(ram_valid), .ram_d(ram_d),
    .ram_a(ram_a), .busy(busy), .done(done)
  );

  lcd_img_proc #(.IMG_W(16), .IMG_H(4), .DATA_W(10), .ADDR_W(6)) dut2 (
    .clk(clk), .reset(reset), .cmd(cmd2), .cmd_valid(cmd_valid2), .rom_q(rom_q2),
    .rom_rd(rom_rd2), .rom_a(rom_a2), .ram_valid(ram_valid2), .ram_d(ram_d2),
    .ram_a(ram_a2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge where reset was just released (load cycle 0)
  task automatic load_chk(input bit pulse_cmd);
    chk("rst_rom_a", rom_a, 0);
    chk("rst_rom_rd", rom_rd, 1);
    chk("rst_busy", busy, 1);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_done", done, 0);
    tick(1);
    chk("ld_rom_a1", rom_a, 1);
    if (pulse_cmd) begin
      cmd = 4'd5;
      cmd_valid = 1'b1;
    end
    tick(1);
    cmd_valid = 1'b0;
    tick(61);
    chk("ld_rom_a63", rom_a, 63);
    chk("ld_rom_rd63", rom_rd, 1);
    tick(1);
    chk("ld_rom_rd64", rom_rd, 0);
    chk("ld_busy64", busy, 1);
    tick(1);
    chk("ld_busy65", busy, 0);
    chk("ld_busy65_dut2", busy2, 0);
  endtask

  task automatic issue1(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic exec1(input logic [3:0] c);
    issue1(c);
    chk("exec_busy", busy, 1);
    tick(1);
  endtask

  task automatic wb1();
    issue1(4'd0);
    for (int a = 0; a < 64; a++) begin
      chk("wb_valid", ram_valid, 1);
      chk("wb_addr", ram_a, a);
      chk("wb_data", ram_d, model1[a]);
      tick(1);
    end
    chk("wb_done", done, 1);
    chk("wb_end_valid", ram_valid, 0);
    chk("wb_end_addr", ram_a, 0);
    chk("wb_end_busy", busy, 0);
    tick(1);
    chk("wb_done_pulse", done, 0);
  endtask

  task automatic exec2(input logic [3:0] c);
    cmd2 = c;
    cmd_valid2 = 1'b1;
    tick(1);
    cmd_valid2 = 1'b0;
    chk("exec2_busy", busy2, 1);
    tick(1);
  endtask

  task automatic wb2();
    cmd2 = 4'd0;
    cmd_valid2 = 1'b1;
    tick(1);
    cmd_valid2 = 1'b0;
    for (int a = 0; a < 64; a++) begin
      chk("wb2_valid", ram_valid2, 1);
      chk("wb2_addr", ram_a2, a);
      chk("wb2_data", ram_d2, model2[a]);
      tick(1);
    end
    chk("wb2_done", done2, 1);
    chk("wb2_end_valid", ram_valid2, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom1[i]   = 8'(i);
      rom2[i]   = (i == 23 || i == 24 || i == 39 || i == 40) ? 10'd1023 : 10'(i);
      model1[i] = i;
      model2[i] = int'(rom2[i]);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    load_chk(1'b0);

    // Wide-pixel instance: origin (7,1) covers 23,24,39,40, all full-scale
    exec2(4'd7);
    exec2(4'd3);
    exec2(4'd5);
    model2[22] = 1023;
    model2[38] = 1023;
    wb2();

    wb1();

    exec1(4'd9);
    model1[27] = 35; model1[28] = 27; model1[35] = 36; model1[36] = 28;
    wb1();
    exec1(4'd8);
    model1[27] = 27; model1[28] = 28; model1[35] = 35; model1[36] = 36;
    wb1();

    exec1(4'd7);
    model1[27] = 31; model1[28] = 31; model1[35] = 31; model1[36] = 31;

    // Reset in the middle of a write-back
    issue1(4'd0);
    tick(20);
    chk("mid_ram_a", ram_a, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", ram_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_rom_a", rom_a, 0);
    chk("mid_rst_rom_rd", rom_rd, 1);
    @(negedge clk);
    reset = 1'b0;
    load_chk(1'b1);
    for (int i = 0; i < 64; i++) model1[i] = i;

    exec1(4'd5);
    model1[27] = 36; model1[28] = 36; model1[35] = 36; model1[36] = 36;
    repeat (4) exec1(4'd3);
    exec1(4'd5);
    model1[24] = 33; model1[25] = 33; model1[32] = 33; model1[33] = 33;
    repeat (5) exec1(4'd1);
    exec1(4'd6);
    model1[1] = 0; model1[8] = 0; model1[9] = 0;
    exec1(4'd4);
    exec1(4'd11);
    exec1(4'd10);
    model1[1] = 10; model1[2] = 0; model1[9] = 2; model1[10] = 0;
    exec1(4'd13);
    wb1();

    repeat (6) exec1(4'd4);
    exec1(4'd7);
    model1[6] = 10; model1[7] = 10; model1[14] = 10; model1[15] = 10;
    repeat (7) exec1(4'd2);
    exec1(4'd6);
    model1[55] = 54; model1[62] = 54; model1[63] = 54;
    wb1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
